// File: rtl/trap_ctrl_if.sv
// Trap controller bus interface.
// Groups the request/mask inputs, the Execute-stage status and the redirect/flush outputs.
//   master : pipeline side (drives irq, mask_we, mask_wdata, PCE, validE, retE)
//   slave  : trap_ctrl side (drives addressSrc, address, Flush*, in_trap, cur_id, pending)
interface trap_ctrl_if #(
  parameter int unsigned NUM_IRQ = 4
) ();
  logic [NUM_IRQ-1:0] irq;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic [31:0]        PCE;
  logic               validE;
  logic               retE;
  logic               addressSrc;
  logic [31:0]        address;
  logic               FlushD;
  logic               FlushE;
  logic               FlushM;
  logic               in_trap;
  logic [3:0]         cur_id;
  logic [NUM_IRQ-1:0] pending;

  modport master (
    output irq, mask_we, mask_wdata, PCE, validE, retE,
    input  addressSrc, address, FlushD, FlushE, FlushM, in_trap, cur_id, pending
  );

  modport slave (
    input  irq, mask_we, mask_wdata, PCE, validE, retE,
    output addressSrc, address, FlushD, FlushE, FlushM, in_trap, cur_id, pending
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap/interrupt controller for the 5-stage pipeline.
// Edge-detects NUM_IRQ request lines into pending bits, masks them, redirects fetch to a
// per-source vector (lowest index wins), saves the Execute PC and returns to it on retE.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : trap_ctrl_if.slave (requests, mask write, Execute status, redirect/flush outputs)
// Optional feature: define TRAP_NESTING_EN to turn the return PC into a NEST_DEPTH-entry LIFO
// and allow preemption by a higher-priority (lower id) source.
module trap_ctrl #(
  parameter int unsigned        NUM_IRQ    = 4,
  parameter logic [31:0]        ISR_BASE   = 32'd76,
  parameter logic [31:0]        VEC_STRIDE = 32'd16,
  parameter logic [NUM_IRQ-1:0] MASK_RESET = '1,
  parameter int unsigned        NEST_DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  trap_ctrl_if.slave bus
);

  if (NUM_IRQ < 1 || NUM_IRQ > 16 || NEST_DEPTH < 1) begin : g_param_err
    $error("trap_ctrl: parameter out of range");
  end

  typedef enum logic [0:0] {StIdle, StTrap} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, pending_q, pending_d, mask_q;
  logic [NUM_IRQ-1:0] eligible, win_oh;
  logic [3:0]         win_id, cur_id_q;
  logic               any_elig, take_ok, take, ret;
  logic [31:0]        ret_pc;

`ifdef TRAP_NESTING_EN
  localparam int unsigned SpW  = $clog2(NEST_DEPTH + 1);
  localparam int unsigned IdxW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [31:0]   stk_pc_q [NEST_DEPTH];
  logic [3:0]    stk_id_q [NEST_DEPTH];
  logic [SpW-1:0] sp_q;
  logic [IdxW-1:0] top_idx, push_idx;

  assign top_idx  = IdxW'(sp_q - 1'b1);
  assign push_idx = IdxW'(sp_q);
  assign ret_pc   = stk_pc_q[top_idx];
`else
  logic [31:0] epc_q;

  assign ret_pc = epc_q;
`endif

  // Priority select: lowest eligible index wins.
  always_comb begin
    eligible = pending_q & mask_q;
    any_elig = |eligible;
    win_id   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 4'(i);
    end
    win_oh = NUM_IRQ'(1) << win_id;
  end

  // Return beats take; bubbles never take since PCE is no valid return point.
  always_comb begin
    ret     = (state_q == StTrap) & bus.retE;
    take_ok = bus.validE & ~bus.retE & any_elig;
`ifdef TRAP_NESTING_EN
    take    = take_ok & ((state_q == StIdle) |
                         ((win_id < cur_id_q) & (sp_q < SpW'(NEST_DEPTH))));
`else
    take    = take_ok & (state_q == StIdle);
`endif
    // A fresh edge in the take cycle re-sets the bit being cleared.
    pending_d = (pending_q & ~(take ? win_oh : '0)) | (bus.irq & ~irq_q);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (take) state_d = StTrap;
      StTrap: begin
        if (ret) begin
`ifdef TRAP_NESTING_EN
          if (sp_q == SpW'(1)) state_d = StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.addressSrc = rst_n & (take | ret);
    bus.address    = ret ? ret_pc : ISR_BASE + 32'(win_id) * VEC_STRIDE;
    bus.FlushD     = bus.addressSrc;
    bus.FlushE     = bus.addressSrc;
    bus.FlushM     = bus.addressSrc;
    bus.in_trap    = (state_q != StIdle);
    bus.cur_id     = cur_id_q;
    bus.pending    = pending_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RESET;
      cur_id_q  <= '0;
`ifdef TRAP_NESTING_EN
      sp_q      <= '0;
      for (int i = 0; i < int'(NEST_DEPTH); i++) begin
        stk_pc_q[i] <= '0;
        stk_id_q[i] <= '0;
      end
`else
      epc_q     <= '0;
`endif
    end else begin
      irq_q     <= bus.irq;
      pending_q <= pending_d;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      if (take) begin
        cur_id_q <= win_id;
`ifdef TRAP_NESTING_EN
        stk_pc_q[push_idx] <= bus.PCE;
        stk_id_q[push_idx] <= cur_id_q;
        sp_q               <= sp_q + 1'b1;
`else
        epc_q    <= bus.PCE;
`endif
      end else if (ret) begin
`ifdef TRAP_NESTING_EN
        cur_id_q <= stk_id_q[top_idx];
        sp_q     <= sp_q - 1'b1;
`else
        cur_id_q <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  localparam int N     = 4;
  localparam int DEPTH = 4;
`ifdef TRAP_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  trap_ctrl_if #(.NUM_IRQ(N)) bus ();

  trap_ctrl #(
    .NUM_IRQ   (N),
    .ISR_BASE  (32'd76),
    .VEC_STRIDE(32'd16),
    .MASK_RESET(4'hF),
    .NEST_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending/mask bit vectors and a queue of saved return frames.
  typedef struct {
    logic [31:0] pc;
    int          id;
  } frame_t;
  frame_t      m_stk[$];
  logic [3:0]  m_pend, m_mask, m_prev;
  int          m_cur;

  logic        obs_as, obs_in;
  logic [31:0] obs_addr;
  logic [3:0]  obs_cur, obs_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_pend = '0;
    m_mask = 4'hF;
    m_prev = '0;
    m_cur  = 0;
  endtask

  // One clock: drive, check combinational outputs against the model, clock, update model.
  task automatic step(input logic rn, input logic [3:0] irq_v, input logic mwe,
                      input logic [3:0] mwd, input logic [31:0] pc, input logic ve,
                      input logic re);
    int          win;
    bit          in_t, do_ret, do_take, exp_as;
    logic [31:0] exp_addr;
    logic [3:0]  edges;
    frame_t      f;
    rst_n          = rn;
    bus.irq        = irq_v;
    bus.mask_we    = mwe;
    bus.mask_wdata = mwd;
    bus.PCE        = pc;
    bus.validE     = ve;
    bus.retE       = re;
    #1;
    win = -1;
    for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i] && win < 0) win = i;
    in_t    = (m_stk.size() > 0);
    do_ret  = in_t && re;
    do_take = ve && !re && (win >= 0) &&
              (!in_t || (NEST && win < m_cur && m_stk.size() < DEPTH));
    exp_as  = rn && (do_ret || do_take);
    exp_addr = do_ret ? m_stk[$].pc : 32'(76 + 16 * win);
    obs_as   = bus.addressSrc;
    obs_addr = bus.address;
    obs_in   = bus.in_trap;
    obs_cur  = bus.cur_id;
    obs_pend = bus.pending;
    chk("addressSrc", {31'd0, bus.addressSrc}, {31'd0, exp_as});
    chk("flush", {29'd0, bus.FlushD, bus.FlushE, bus.FlushM}, {29'd0, {3{exp_as}}});
    chk("in_trap", {31'd0, bus.in_trap}, {31'd0, in_t});
    chk("cur_id", {28'd0, bus.cur_id}, 32'(m_cur));
    chk("pending", {28'd0, bus.pending}, {28'd0, m_pend});
    if (exp_as) chk("address", bus.address, exp_addr);
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      edges = irq_v & ~m_prev;
      if (do_take) begin
        f.pc = pc;
        f.id = m_cur;
        m_stk.push_back(f);
        m_cur = win;
        m_pend[win] = 1'b0;
      end else if (do_ret) begin
        f = m_stk.pop_back();
        m_cur = f.id;
      end
      m_pend = m_pend | edges;
      m_prev = irq_v;
      if (mwe) m_mask = mwd;
    end
    @(negedge clk);
  endtask

  logic [3:0] irq_r;

  initial begin
    rst_n          = 1'b0;
    bus.irq        = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.PCE        = '0;
    bus.validE     = 1'b0;
    bus.retE       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();

    // Reset held; spurious retE and a valid request must not redirect.
    step(1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    chk("rst_pending", {28'd0, obs_pend}, 32'd0);
    chk("rst_in_trap", {31'd0, obs_in}, 32'd0);

    // Single source: irq[2] -> vector 108, return to 0x40.
    step(1'b1, 4'h4, 1'b0, 4'h0, 32'h3c, 1'b0, 1'b0);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h40, 1'b1, 1'b0);
    chk("t2_as", {31'd0, obs_as}, 32'd1);
    chk("t2_addr", obs_addr, 32'd108);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h44, 1'b1, 1'b0);
    chk("t2_cur", {28'd0, obs_cur}, 32'd2);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h48, 1'b1, 1'b1);
    chk("t2_ret", obs_addr, 32'h40);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h40, 1'b0, 1'b0);
    chk("t2_idle", {31'd0, obs_in}, 32'd0);

    // Simultaneous irq[1]/irq[3]: 92 first, 124 after return.
    step(1'b1, 4'hA, 1'b0, 4'h0, 32'h50, 1'b0, 1'b0);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h54, 1'b1, 1'b0);
    chk("t3_first", obs_addr, 32'd92);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h60, 1'b1, 1'b1);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h54, 1'b1, 1'b0);
    chk("t3_second", obs_addr, 32'd124);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h70, 1'b1, 1'b1);

    // Masked source held pending, taken after unmask.
    step(1'b1, 4'h0, 1'b1, 4'hE, 32'h80, 1'b0, 1'b0);
    step(1'b1, 4'h1, 1'b0, 4'h0, 32'h84, 1'b1, 1'b0);
    step(1'b1, 4'h1, 1'b0, 4'h0, 32'h88, 1'b1, 1'b0);
    chk("t4_masked", {31'd0, obs_as}, 32'd0);
    chk("t4_held", {28'd0, obs_pend}, 32'd1);
    step(1'b1, 4'h0, 1'b1, 4'hF, 32'h8c, 1'b1, 1'b0);
    chk("t4_mask_lat", {31'd0, obs_as}, 32'd0);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h90, 1'b1, 1'b0);
    chk("t4_take", obs_addr, 32'd76);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h94, 1'b1, 1'b1);

    // Return beats a simultaneous request; bubbles don't take.
    step(1'b1, 4'h4, 1'b0, 4'h0, 32'ha0, 1'b0, 1'b0);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'ha4, 1'b1, 1'b0);
    step(1'b1, 4'h2, 1'b0, 4'h0, 32'hc0, 1'b0, 1'b0);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'hc4, 1'b1, 1'b1);
    chk("t5_ret", obs_addr, 32'ha4);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'ha4, 1'b0, 1'b0);
    chk("t5_bubble", {31'd0, obs_as}, 32'd0);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'ha4, 1'b1, 1'b0);
    chk("t5_take", obs_addr, 32'd92);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'hd0, 1'b1, 1'b1);

    // Handler 3 running, irq[0] arrives.
    step(1'b1, 4'h8, 1'b0, 4'h0, 32'h100, 1'b0, 1'b0);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h100, 1'b1, 1'b0);
    step(1'b1, 4'h1, 1'b0, 4'h0, 32'h200, 1'b1, 1'b0);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h204, 1'b1, 1'b0);
`ifdef TRAP_NESTING_EN
    chk("t6_preempt", obs_addr, 32'd76);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h50, 1'b1, 1'b1);
    chk("t6_ret1", obs_addr, 32'h204);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h208, 1'b1, 1'b0);
    chk("t6_cur3", {28'd0, obs_cur}, 32'd3);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h20c, 1'b1, 1'b1);
    chk("t6_ret2", obs_addr, 32'h100);
`else
    chk("t6_no_preempt", {31'd0, obs_as}, 32'd0);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h208, 1'b1, 1'b1);
    chk("t6_ret", obs_addr, 32'h100);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h100, 1'b1, 1'b0);
    chk("t6_late", obs_addr, 32'd76);
    step(1'b1, 4'h0, 1'b0, 4'h0, 32'h300, 1'b1, 1'b1);
`endif

    // Randomized traffic, including occasional mid-handler resets.
    irq_r = '0;
    for (int c = 0; c < 600; c++) begin
      irq_r = irq_r ^ 4'($urandom & $urandom & $urandom);
      step(($urandom_range(0, 99) != 0), irq_r, ($urandom_range(0, 15) == 0),
           4'($urandom), {$urandom_range(0, 32'h3fff_ffff), 2'b00},
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
